// File: rtl/conv_layer_tdm.sv
// Time-multiplexed conv/FC layer: buffers one frame, runs OUTPUT_NUM dot products on PE_NUM MAC
// lanes, then adds bias, rescales, saturates and applies the activation.
module conv_layer_tdm #(
    parameter int    INPUT_NUM        = 16,
    parameter int    OUTPUT_NUM       = 120,
    parameter int    NUM_WEIGHT       = 25,
    parameter int    PE_NUM           = 8,
    parameter int    DATA_WIDTH       = 16,
    parameter int    WEIGHT_INT_WIDTH = 1,
    parameter string ACT_TYPE         = "Relu",
    localparam int   WA               = $clog2(OUTPUT_NUM * NUM_WEIGHT),
    localparam int   BA               = $clog2(OUTPUT_NUM)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*INPUT_NUM-1:0]  in_data,
    input  logic                             wt_we,
    input  logic [WA-1:0]                    wt_addr,
    input  logic [DATA_WIDTH*INPUT_NUM-1:0]  wt_data,
    input  logic                             bias_we,
    input  logic [BA-1:0]                    bias_addr,
    input  logic [DATA_WIDTH-1:0]            bias_data,
    output logic                             busy,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*OUTPUT_NUM-1:0] out_data
);
    localparam int DW   = DATA_WIDTH;
    localparam int XW   = DATA_WIDTH * INPUT_NUM;
    localparam int G    = (OUTPUT_NUM + PE_NUM - 1) / PE_NUM;
    localparam int FRAC = DATA_WIDTH - 1 - WEIGHT_INT_WIDTH;
    localparam int PW   = 2 * DATA_WIDTH + $clog2(INPUT_NUM);
    localparam int AW   = 2 * DATA_WIDTH + $clog2(INPUT_NUM * NUM_WEIGHT);
    localparam int SW   = AW + 1;
    localparam int PXW  = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam int GW   = $clog2(G + 1);
    localparam int BKW  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam int RW   = (G * NUM_WEIGHT > 1) ? $clog2(G * NUM_WEIGHT) : 1;
    localparam bit RELU = (ACT_TYPE == "Relu");

    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = -SW'(2 ** (DW - 1));

    localparam logic [1:0] StLoad    = 2'd0;
    localparam logic [1:0] StCompute = 2'd1;
    localparam logic [1:0] StOut     = 2'd2;

    logic [1:0]          state_q;
    logic [PXW-1:0]      pix_q;
    logic [GW-1:0]       grp_q;
    logic                accept, issue;
    logic [RW-1:0]       rd_row;

    logic [XW-1:0]       frame_q [NUM_WEIGHT];
    logic [XW-1:0]       wmem    [PE_NUM][G*NUM_WEIGHT];
    logic [DW-1:0]       bmem    [OUTPUT_NUM];

    logic                s1_valid, s1_first, s1_last;
    logic [GW-1:0]       s1_grp;
    logic [XW-1:0]       x_q;
    logic [XW-1:0]       rd_q    [PE_NUM];
    logic                s2_valid, s2_first, s2_last;
    logic [GW-1:0]       s2_grp;
    logic signed [PW-1:0] prod_q [PE_NUM];
    logic signed [AW-1:0] acc_q  [PE_NUM];
    logic                s3_done;
    logic [GW-1:0]       s3_grp;
    logic [DW-1:0]       out_q   [OUTPUT_NUM];

    int                  wt_o, wt_p;
    logic [BKW-1:0]      wt_bank;
    logic [RW-1:0]       wt_row;
    logic                wt_ok, bias_ok;

    function automatic logic signed [PW-1:0] dot(input logic [XW-1:0] x, input logic [XW-1:0] w);
        logic signed [PW-1:0]   s;
        logic signed [2*DW-1:0] p;
        s = '0;
        for (int c = 0; c < INPUT_NUM; c++) begin
            p = $signed(x[c*DW +: DW]) * $signed(w[c*DW +: DW]);
            s = s + PW'(p);
        end
        return s;
    endfunction

    // Bias is aligned to the accumulator's 2*FRAC scale before the floor shift back to FRAC.
    function automatic logic [DW-1:0] post_fn(input logic signed [AW-1:0] acc,
                                              input logic [DW-1:0] b);
        logic signed [SW-1:0] sum, sh;
        logic [DW-1:0]        r;
        sum = SW'(acc) + (SW'($signed(b)) <<< FRAC);
        sh  = sum >>> FRAC;
        if (sh > SAT_MAX)      r = SAT_MAX[DW-1:0];
        else if (sh < SAT_MIN) r = SAT_MIN[DW-1:0];
        else                   r = sh[DW-1:0];
        if (RELU && r[DW-1]) r = '0;
        return r;
    endfunction

    assign in_ready  = (state_q == StLoad);
    assign busy      = (state_q == StCompute);
    assign out_valid = (state_q == StOut);
    assign accept    = in_valid && in_ready;
    assign issue     = (state_q == StCompute) && (int'(grp_q) < G);
    assign rd_row    = RW'(int'(grp_q) * NUM_WEIGHT + int'(pix_q));

    // Row o*NUM_WEIGHT+p lives in bank o%PE_NUM at row (o/PE_NUM)*NUM_WEIGHT+p.
    always_comb begin
        wt_o    = int'(wt_addr) / NUM_WEIGHT;
        wt_p    = int'(wt_addr) % NUM_WEIGHT;
        wt_bank = BKW'(wt_o % PE_NUM);
        wt_row  = RW'((wt_o / PE_NUM) * NUM_WEIGHT + wt_p);
        wt_ok   = wt_we && (state_q != StCompute) && (int'(wt_addr) < OUTPUT_NUM * NUM_WEIGHT);
        bias_ok = bias_we && (state_q != StCompute) && (int'(bias_addr) < OUTPUT_NUM);
    end

    always_ff @(posedge clk) begin
        if (accept) frame_q[pix_q] <= in_data;
        if (wt_ok) wmem[wt_bank][wt_row] <= wt_data;
        if (bias_ok) bmem[bias_addr] <= bias_data;
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            x_q <= frame_q[pix_q];
            for (int l = 0; l < PE_NUM; l++) rd_q[l] <= wmem[l][rd_row];
        end
        if (s1_valid) begin
            for (int l = 0; l < PE_NUM; l++) prod_q[l] <= dot(x_q, rd_q[l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StLoad;
            pix_q    <= '0;
            grp_q    <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_grp   <= '0;
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_grp   <= '0;
            s3_done  <= 1'b0;
            s3_grp   <= '0;
            for (int l = 0; l < PE_NUM; l++) acc_q[l] <= '0;
            for (int o = 0; o < OUTPUT_NUM; o++) out_q[o] <= '0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (accept) begin
                        if (pix_q == PXW'(NUM_WEIGHT - 1)) begin
                            pix_q   <= '0;
                            grp_q   <= '0;
                            state_q <= StCompute;
                        end else begin
                            pix_q <= pix_q + 1'b1;
                        end
                    end
                end
                StCompute: begin
                    if (issue) begin
                        if (pix_q == PXW'(NUM_WEIGHT - 1)) begin
                            pix_q <= '0;
                            grp_q <= grp_q + 1'b1;
                        end else begin
                            pix_q <= pix_q + 1'b1;
                        end
                    end
                    if (s3_done && int'(s3_grp) == G - 1) state_q <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        state_q <= StLoad;
                        grp_q   <= '0;
                    end
                end
                default: state_q <= StLoad;
            endcase

            s1_valid <= issue;
            s1_first <= (pix_q == '0);
            s1_last  <= (pix_q == PXW'(NUM_WEIGHT - 1));
            s1_grp   <= grp_q;
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_grp   <= s1_grp;

            // First pixel of a group restarts the lane, so no clear cycle between groups.
            if (s2_valid) begin
                for (int l = 0; l < PE_NUM; l++)
                    acc_q[l] <= s2_first ? AW'(prod_q[l]) : acc_q[l] + AW'(prod_q[l]);
            end
            s3_done <= s2_valid && s2_last;
            s3_grp  <= s2_grp;

            if (s3_done) begin
                for (int o = 0; o < OUTPUT_NUM; o++)
                    if (o / PE_NUM == int'(s3_grp))
                        out_q[o] <= post_fn(acc_q[o % PE_NUM], bmem[o]);
            end
        end
    end

    for (genvar o = 0; o < OUTPUT_NUM; o++) begin : g_pack
        assign out_data[o*DW +: DW] = out_q[o];
    end

endmodule
